// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU operation codes, RV32I opcodes, operand selects and skid entry.
// ALU_DECODE_ILLEGAL_EN (optional) enables the illegal-encoding checker in alu_ctrl_decode.
package alu_pkg;

  localparam int DataW = 32;

  typedef enum logic [2:0] {
    AND    = 3'b000,
    OR     = 3'b001,
    XOR    = 3'b010,
    ADDSUB = 3'b011,
    SHR    = 3'b100,
    SHL    = 3'b101,
    SLTU   = 3'b110,
    SLT    = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] ASEL_RS1  = 2'd0;
  localparam logic [1:0] ASEL_PC   = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;
  localparam logic [1:0] BSEL_RS2  = 2'd0;
  localparam logic [1:0] BSEL_IMM  = 2'd1;
  localparam logic [1:0] BSEL_FOUR = 2'd2;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    alu_op_e          op;
    logic             cin;
    logic [DataW-1:0] a;
    logic [DataW-1:0] b;
    logic             illegal;
  } skid_entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I opcode/funct decode into ALU operation, carry-in and operand selects.
// ALU_DECODE_ILLEGAL_EN adds the illegal-encoding flag; otherwise illegal_o is tied low.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [2:0] alu_op_o,
  output logic       alu_cin_o,
  output logic [1:0] a_sel_o,
  output logic [1:0] b_sel_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ADDSUB;
    alu_cin_o = 1'b0;
    a_sel_o   = ASEL_RS1;
    b_sel_o   = BSEL_IMM;
    case (opcode_i)
      OPC_OP, OPC_OP_IMM: begin
        if (opcode_i == OPC_OP) b_sel_o = BSEL_RS2;
        case (funct3_i)
          3'b000: alu_cin_o = (opcode_i == OPC_OP) && funct7_i[5];
          3'b001: alu_op_o = SHL;
          3'b010: begin alu_op_o = SLT;  alu_cin_o = 1'b1; end
          3'b011: begin alu_op_o = SLTU; alu_cin_o = 1'b1; end
          3'b100: alu_op_o = XOR;
          3'b101: begin alu_op_o = SHR;  alu_cin_o = funct7_i[5]; end
          3'b110: alu_op_o = OR;
          default: alu_op_o = AND;
        endcase
      end
      OPC_BRANCH: begin
        b_sel_o = BSEL_RS2;
        // Compares are subtractions; reserved funct3 010/011 fall back to plain add.
        case (funct3_i[2:1])
          2'b00: alu_cin_o = 1'b1;
          2'b10: begin alu_op_o = SLT;  alu_cin_o = 1'b1; end
          2'b11: begin alu_op_o = SLTU; alu_cin_o = 1'b1; end
          default: alu_cin_o = 1'b0;
        endcase
      end
      OPC_JAL: begin
        a_sel_o = ASEL_PC;
        b_sel_o = BSEL_FOUR;
      end
      OPC_JALR:  b_sel_o = BSEL_FOUR;
      OPC_AUIPC: a_sel_o = ASEL_PC;
      OPC_LUI:   a_sel_o = ASEL_ZERO;
      default:   a_sel_o = ASEL_RS1;
    endcase
  end

`ifdef ALU_DECODE_ILLEGAL_EN
  always_comb begin
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        if (funct7_i != 7'b0000000 && funct7_i != 7'b0100000) illegal_o = 1'b1;
        else if (funct7_i == 7'b0100000 && funct3_i != 3'b000 && funct3_i != 3'b101) illegal_o = 1'b1;
      end
      OPC_OP_IMM: begin
        if (funct3_i == 3'b001 && funct7_i != 7'b0000000) illegal_o = 1'b1;
        else if (funct3_i == 3'b101 && funct7_i != 7'b0000000 && funct7_i != 7'b0100000) illegal_o = 1'b1;
      end
      OPC_BRANCH: illegal_o = (funct3_i[2:1] == 2'b01);
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI: illegal_o = 1'b0;
      default: illegal_o = 1'b1;
    endcase
  end
`else
  logic unused_funct7;
  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand forwarding, 2-entry skid buffer; 1-cycle latency, in_ready registered (!full).
// ALU_DECODE_ILLEGAL_EN (optional) registers an illegal-encoding flag with each entry.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int Width    = 32,
  parameter int RegAddrW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [RegAddrW-1:0] rs1_addr,
  input  logic [RegAddrW-1:0] rs2_addr,
  input  logic [Width-1:0]    rs1_data,
  input  logic [Width-1:0]    rs2_data,
  input  logic [Width-1:0]    pc,
  input  logic [Width-1:0]    imm,
  input  logic                fwd_exm_we,
  input  logic [RegAddrW-1:0] fwd_exm_rd,
  input  logic [Width-1:0]    fwd_exm_data,
  input  logic                fwd_mwb_we,
  input  logic [RegAddrW-1:0] fwd_mwb_rd,
  input  logic [Width-1:0]    fwd_mwb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          alu_op,
  output logic                alu_cin,
  output logic [Width-1:0]    alu_a,
  output logic [Width-1:0]    alu_b,
  output logic                illegal
);

  logic [2:0] dec_op;
  logic       dec_cin;
  logic [1:0] dec_a_sel;
  logic [1:0] dec_b_sel;
  logic       dec_illegal;

  alu_ctrl_decode u_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .alu_op_o  (dec_op),
    .alu_cin_o (dec_cin),
    .a_sel_o   (dec_a_sel),
    .b_sel_o   (dec_b_sel),
    .illegal_o (dec_illegal)
  );

  // EX/MEM is younger than MEM/WB so it takes priority; x0 is hard-wired to zero.
  logic [Width-1:0] rs1_val, rs2_val, op_a, op_b;
  assign rs1_val = (rs1_addr == '0) ? '0 :
                   (fwd_exm_we && fwd_exm_rd == rs1_addr) ? fwd_exm_data :
                   (fwd_mwb_we && fwd_mwb_rd == rs1_addr) ? fwd_mwb_data : rs1_data;
  assign rs2_val = (rs2_addr == '0) ? '0 :
                   (fwd_exm_we && fwd_exm_rd == rs2_addr) ? fwd_exm_data :
                   (fwd_mwb_we && fwd_mwb_rd == rs2_addr) ? fwd_mwb_data : rs2_data;

  always_comb begin
    case (dec_a_sel)
      ASEL_PC:   op_a = pc;
      ASEL_ZERO: op_a = '0;
      default:   op_a = rs1_val;
    endcase
    case (dec_b_sel)
      BSEL_RS2:  op_b = rs2_val;
      BSEL_FOUR: op_b = Width'(4);
      default:   op_b = imm;
    endcase
  end

  skid_entry_t new_e;
  always_comb begin
    new_e.op      = alu_op_e'(dec_op);
    new_e.cin     = dec_cin;
    new_e.a       = op_a;
    new_e.b       = op_b;
    new_e.illegal = dec_illegal;
  end

  skid_state_e state_q, state_d;
  skid_entry_t head_q, head_d, tail_q, tail_d;
  logic        in_ready_q, in_ready_d;
  logic        accept, drain;

  assign out_valid = (state_q != SK_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;

  // head_q drives the ALU and only changes on drain or when empty, keeping outputs stable under stall.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = SK_EMPTY;
    end else begin
      case (state_q)
        SK_EMPTY: if (accept) begin
          head_d  = new_e;
          state_d = SK_ONE;
        end
        SK_ONE: begin
          if (accept && drain) begin
            head_d = new_e;
          end else if (accept) begin
            tail_d  = new_e;
            state_d = SK_FULL;
          end else if (drain) begin
            state_d = SK_EMPTY;
          end
        end
        SK_FULL: if (drain) begin
          head_d  = tail_q;
          state_d = SK_ONE;
        end
        default: state_d = SK_EMPTY;
      endcase
    end
    in_ready_d = (state_d != SK_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SK_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign alu_op   = head_q.op;
  assign alu_cin  = head_q.cin;
  assign alu_a    = head_q.a;
  assign alu_b    = head_q.b;
  assign illegal  = head_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary stage directly upstream of the 32-bit ALU.
- Decodes RV32I opcode/funct3/funct7 into the ALU's 3-bit Operation and Cin controls.
- Selects and forwards operands, then registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Outputs drive ALU Operation, Cin, A and B directly; ALU result returns to the EX/MEM register, not to this block.

Parameters:
- Width, 32, datapath width of operands and immediates.
- RegAddrW, 5, register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has a decoded instruction.
- in_ready  output  1  stage can accept this cycle.
- opcode  input  7  instruction[6:0].
- funct3  input  3  instruction[14:12].
- funct7  input  7  instruction[31:25].
- rs1_addr, rs2_addr  input  RegAddrW  source indices.
- rs1_data, rs2_data  input  Width  register-file read data.
- pc  input  Width  instruction address.
- imm  input  Width  sign-extended immediate.
- fwd_exm_we  input  1  EX/MEM will write rd.
- fwd_exm_rd  input  RegAddrW  EX/MEM destination.
- fwd_exm_data  input  Width  EX/MEM result.
- fwd_mwb_we, fwd_mwb_rd, fwd_mwb_data  input  1/RegAddrW/Width  MEM/WB equivalents.
- out_valid  output  1  ALU inputs valid.
- out_ready  input  1  downstream accepts.
- alu_op  output  3  ALU Operation code.
- alu_cin  output  1  ALU Cin.
- alu_a, alu_b  output  Width  ALU operands.
- illegal  output  1  illegal-encoding flag (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): both skid entries invalid; out_valid=0, in_ready=1, alu_op=0, alu_cin=0, alu_a=0, alu_b=0, illegal=0.
- Handshake:
  - Transfer occurs when valid&ready at the clock edge.
  - Latency is 1 cycle from input transfer to out_valid.
  - in_ready is registered and equals !skid_full, so it has no combinational path from out_ready.
  - Entries leave in FIFO order.
  - Output fields are stable while out_valid=1 and out_ready=0.
- Skid states:
  - EMPTY → ONE on accept.
  - ONE → FULL on accept without drain.
  - FULL → ONE on drain; no accept in FULL.
  - Accept and drain in the same cycle in ONE stays ONE.
- flush: next cycle both entries are invalid and out_valid=0. Flush beats a same-cycle accept, which is discarded. in_ready=1 after flush.
- Decode, R-type (0110011) and I-ALU (0010011):
  - funct3 000 → op 011; cin=1 only for R-type with funct7[5]=1 (SUB), else 0.
  - funct3 001 → op 101, cin 0.
  - funct3 010 → op 111, cin 1.
  - funct3 011 → op 110, cin 1.
  - funct3 100 → op 010.
  - funct3 101 → op 100, cin=funct7[5] (SRA/SRAI arithmetic).
  - funct3 110 → op 001.
  - funct3 111 → op 000.
- Decode, branch (1100011):
  - BEQ/BNE → op 011, cin 1.
  - BLT/BGE → op 111, cin 1.
  - BLTU/BGEU → op 110, cin 1.
- Decode, add-type (op 011, cin 0): load, store, JAL, JALR, AUIPC, LUI. Any other opcode also decodes as op 011, cin 0.
- Operand A: rs1 for R, I-ALU, load, store, JALR and branch; pc for AUIPC and JAL; 0 for LUI.
- Operand B: rs2 for R and branch; imm for all others, except JAL/JALR where B=4.
- Immediate shifts: B=imm, and the ALU uses only B[4:0].
- Forwarding applies before the register to rs1/rs2 values:
  - EX/MEM match wins over MEM/WB.
  - A match requires we=1 and rd==rsN and rd!=0.
  - x0 always reads 0 regardless of rs*_data.

Optional Feature:
- Macro ALU_DECODE_ILLEGAL_EN.
- When defined, illegal=1 for the entry when any of the following holds, registered with it:
  - R-type funct7 is not 0000000 and not 0100000.
  - R-type funct7=0100000 with funct3 other than 000/101.
  - SLLI funct7 is not 0.
  - SRLI/SRAI funct7 is not 0000000/0100000.
  - Branch funct3 is 010/011.
  - The opcode is unrecognised.
- Flagged entries still pass with the default decode.
- When undefined, illegal is tied 0 and no checker logic is generated.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e: AND=000, OR=001, XOR=010, ADDSUB=011, SHR=100, SHL=101, SLTU=110, SLT=111.
  - RV32I opcode localparams.
  - A packed struct for a skid entry: op, cin, a, b, illegal.
- Sub-module alu_ctrl_decode: combinational opcode/funct → {alu_op, alu_cin, a_sel, b_sel, illegal}.
- Forwarding muxes and skid buffer live in alu_issue_stage.

Test Plan:
- SUB x3,x1,x2 with rs1=10, rs2=3, no forwarding, out_ready=1 → next cycle out_valid=1, op=011, cin=1, a=10, b=3.
- SRAI with funct7=0100000, imm=4, rs1=0xF000_0000 → op=100, cin=1, a=0xF000_0000, b[4:0]=4.
- rs1=5, fwd_exm_rd=5/we/data=0xAA, fwd_mwb_rd=5/data=0xBB → a=0xAA. Repeat with rs1=0 and all forwards rd=0 → a=0.
- Hold out_ready=0 and push 3 instructions back-to-back → in_ready falls after 2 accepts. Raise out_ready → entries emerge in order with stable fields while stalled.
- FULL buffer; assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed instruction never appears.
- Assert rst_n=0 mid-stall, asynchronously → out_valid=0, alu_a=0 immediately. With ALU_DECODE_ILLEGAL_EN, R-type funct7=0000001 → illegal=1.
